// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: EX-stage request/result bundle for the HI/LO unit.
// master = pipeline side, slave = multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide with HI/LO.
// Option MDU_FAST_MULT_EN: MULT/MULTU via a combinational multiplier.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

`ifdef MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] dvd_q;
  logic             is_div_q;
  logic             neg_q;
  logic             rneg_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_mul;
  logic             is_dv;
  logic             iter_op;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign is_mul  = bus.op[2:1] == 2'b00;
  assign is_dv   = bus.op[2:1] == 2'b01;
  assign iter_op = is_dv | (is_mul & ~FAST);
  assign sgn     = ~bus.op[0];
  assign a_neg   = sgn & bus.in1[WIDTH-1];
  assign b_neg   = sgn & bus.in2[WIDTH-1];
  assign a_mag   = a_neg ? -bus.in1 : bus.in1;
  assign b_mag   = b_neg ? -bus.in2 : bus.in2;

  // one shift-add step: {carry, hi} + multiplicand, then shift right
  assign sum = {1'b0, acc_hi_q} +
               (acc_lo_q[0] ? {1'b0, m_q} : '0);
  // one restoring step: bring in next dividend bit, trial subtract
  assign sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign trial = sh - {1'b0, m_q};

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -acc_lo_q : acc_lo_q;
  assign r_fix    = rneg_q ? -acc_hi_q : acc_hi_q;

`ifdef MDU_FAST_MULT_EN
  logic               fast_q;
  logic [2*WIDTH-1:0] fprod_q;
  logic [2*WIDTH-1:0] fmag;
  assign fmag = {{WIDTH{1'b0}}, a_mag} *
                {{WIDTH{1'b0}}, b_mag};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start && iter_op) state_d = CALC;
      CALC: if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_FAST_MULT_EN
      fast_q   <= 1'b0;
      fprod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
`ifdef MDU_FAST_MULT_EN
      fast_q  <= 1'b0;
      if (fast_q) begin
        hi_q   <= fprod_q[2*WIDTH-1:WIDTH];
        lo_q   <= fprod_q[WIDTH-1:0];
        done_q <= 1'b1;
      end
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.start && iter_op) begin
            cnt_q    <= '0;
            is_div_q <= is_dv;
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dz_q     <= bus.in2 == '0;
            dvd_q    <= bus.in1;
            acc_hi_q <= '0;
            acc_lo_q <= is_dv ? a_mag : b_mag;
            m_q      <= is_dv ? b_mag : a_mag;
          end
`ifdef MDU_FAST_MULT_EN
          if (bus.start && is_mul) begin
            fast_q  <= 1'b1;
            fprod_q <= (a_neg ^ b_neg) ? -fmag : fmag;
          end
`endif
          // a later MTHI/MTLO overrides a same-edge fast writeback
          if (bus.start && bus.op == OP_MTHI) hi_q <= bus.in1;
          if (bus.start && bus.op == OP_MTLO) lo_q <= bus.in1;
        end
        CALC: begin
          if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
              acc_hi_q <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
              acc_hi_q <= sum[WIDTH:1];
              acc_lo_q <= {sum[0], acc_lo_q[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= dvd_q;
            lo_q <= '1;
          end else begin
            hi_q <= r_fix;
            lo_q <= q_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven vectors plus hand-written corner sequences.
module tb_mul_div_unit;
  localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic reset;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];
  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // starts near a posedge+1; returns at the negedge where done is seen
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) return;
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  initial begin
    int lat;
    int bc;
    int exp_lat;
    int exp_bc;
    int pulses;
    int hold_err;
    int gap;

    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{"multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg3x7", 3'b000, 32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_by0", 3'b011, 32'd100, 32'd0,
                32'd100, 32'hFFFFFFFF};
    vecs[4] = '{"div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000};
    vecs[5] = '{"divu_1000_3", 3'b011, 32'd1000, 32'd3,
                32'd1, 32'd333};
    vecs[6] = '{"mult_minsq", 3'b000, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000};
    vecs[7] = '{"div_7_m2", 3'b010, 32'd7, 32'hFFFFFFFE,
                32'd1, 32'hFFFFFFFD};
    vecs[8] = '{"multu_shift", 3'b001, 32'h12345678, 32'h10,
                32'h00000001, 32'h23456780};
    vecs[9] = '{"div_neg_by0", 3'b010, 32'hFFFFFF9C, 32'd0,
                32'hFFFFFF9C, 32'hFFFFFFFF};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.in1   = '0;
    bus.in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      exp_lat = (FAST && vecs[i].op[2:1] == 2'b00) ? 1 : W + 2;
      exp_bc  = (FAST && vecs[i].op[2:1] == 2'b00) ? 0 : W + 2;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bc);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({vecs[i].name, "_busy"}, 32'(bc), 32'(exp_bc));
      chk({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_pulse"}, 32'(bus.done), 32'd0);
    end

    // MTHI while busy must be dropped
    issue(3'b011, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    issue(3'b100, 32'h12345678, 32'd0);
    wait_done(lat, bc);
    chk("mthi_busy_to", 32'(lat >= 0), 32'd1);
    chk("mthi_busy_hi", bus.hi, 32'd1);
    chk("mthi_busy_lo", bus.lo, 32'd333);
    @(posedge clk);
    #1;

    issue(3'b100, 32'h12345678, 32'd0);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo", bus.lo, 32'd333);
    chk("mthi_done", 32'(bus.done), 32'd0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    issue(3'b101, 32'hCAFEF00D, 32'd0);
    chk("mtlo_lo", bus.lo, 32'hCAFEF00D);
    chk("mtlo_hi", bus.hi, 32'h12345678);
    issue(3'b111, 32'hDEADBEEF, 32'd5);
    @(posedge clk);
    #1;
    chk("undef_hi", bus.hi, 32'h12345678);
    chk("undef_lo", bus.lo, 32'hCAFEF00D);
    chk("undef_busy", 32'(bus.busy), 32'd0);

    // reset ten cycles into a divide
    issue(3'b011, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    issue(3'b011, 32'd1000, 32'd3);
    wait_done(lat, bc);
    chk("redo_lat", 32'(lat), 32'(W + 2));
    chk("redo_hi", bus.hi, 32'd1);
    chk("redo_lo", bus.lo, 32'd333);
    @(posedge clk);
    #1;

    // DIVU issued in the done cycle of a MULTU
    issue(3'b001, 32'd3, 32'd5);
    wait_done(lat, bc);
    chk("b2b_mul_hi", bus.hi, 32'd0);
    chk("b2b_mul_lo", bus.lo, 32'd15);
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.op    = 3'b011;
    bus.in1   = 32'd1000;
    bus.in2   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    hold_err  = 0;
    gap       = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        gap = i;
        break;
      end
      if (bus.hi !== 32'd0 || bus.lo !== 32'd15) hold_err++;
    end
    chk("b2b_gap", 32'(gap), 32'(W + 2));
    chk("b2b_hold", 32'(hold_err), 32'd0);
    chk("b2b_div_hi", bus.hi, 32'd1);
    chk("b2b_div_lo", bus.lo, 32'd333);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
